// File: rtl/slurm16_memory_arbiter.sv
// Single-port 16-bit memory arbiter for fetch, load/store and DMA requesters.
// One grant per cycle; read data returns one cycle later tagged to its owner.
module slurm16_memory_arbiter #(
    parameter int ADDR_BITS     = 15,
    parameter int STARVE_LIMIT  = 4,
    parameter int DMA_BURST_MAX = 8
) (
    input  logic                 CLK,
    input  logic                 RSTb,

    input  logic                 instr_req,
    input  logic [ADDR_BITS-1:0] instr_addr,
    output logic                 instr_grant,
    output logic                 instr_valid,
    output logic [15:0]          instr_data,
    output logic [ADDR_BITS-1:0] instr_addr_out,

    input  logic                 data_req,
    input  logic                 data_wr,
    input  logic [ADDR_BITS-1:0] data_addr,
    input  logic [15:0]          data_wdata,
    input  logic [1:0]           data_mask,
    output logic                 data_success,
    output logic                 data_rvalid,
    output logic [15:0]          data_rdata,

    input  logic                 dma_req,
    input  logic                 dma_wr,
    input  logic [ADDR_BITS-1:0] dma_addr,
    input  logic [15:0]          dma_wdata,
    output logic                 dma_grant,
    output logic                 dma_rvalid,
    output logic [15:0]          dma_rdata,

    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    output logic [1:0]           mem_wr_mask,
    output logic [15:0]          mem_wdata,
    input  logic [15:0]          mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(DMA_BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_MAX  = BW'(DMA_BURST_MAX);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2,
        OWN_DMA   = 2'd3
    } owner_t;

    owner_t               owner_q, owner_d, win;
    logic [SW-1:0]        starve_cnt_q, starve_cnt_d;
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
    logic [ADDR_BITS-1:0] instr_addr_out_q, instr_addr_out_d;
    logic                 dma_yield;

    assign dma_yield = (burst_cnt_q == BURST_MAX) && (instr_req || data_req);

    // Priority chain; reset suppresses every grant.
    always_comb begin
        win = OWN_NONE;
        if (!RSTb)                                        win = OWN_NONE;
        else if ((starve_cnt_q == STARVE_MAX) && instr_req) win = OWN_INSTR;
        else if (data_req)                                win = OWN_DATA;
        else if (dma_req && !dma_yield)                   win = OWN_DMA;
        else if (instr_req)                               win = OWN_INSTR;
        else if (dma_req)                                 win = OWN_DMA;
    end

    always_comb begin
        instr_grant  = (win == OWN_INSTR);
        data_success = (win == OWN_DATA);
        dma_grant    = (win == OWN_DMA);
        mem_addr     = instr_addr;
        mem_rd       = 1'b0;
        mem_wr_mask  = 2'b00;
        mem_wdata    = data_wdata;
        owner_d      = OWN_NONE;
        case (win)
            OWN_INSTR: begin
                mem_rd  = 1'b1;
                owner_d = OWN_INSTR;
            end
            OWN_DATA: begin
                mem_addr = data_addr;
                if (data_wr) begin
                    mem_wr_mask = data_mask;
                end else begin
                    mem_rd  = 1'b1;
                    owner_d = OWN_DATA;
                end
            end
            OWN_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                if (dma_wr) begin
                    mem_wr_mask = 2'b11;
                end else begin
                    mem_rd  = 1'b1;
                    owner_d = OWN_DMA;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_cnt_d = '0;
        if (instr_req && (win != OWN_INSTR))
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX : starve_cnt_q + 1'b1;
        burst_cnt_d = '0;
        if (win == OWN_DMA)
            burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + 1'b1;
        instr_addr_out_d = (win == OWN_INSTR) ? instr_addr : instr_addr_out_q;
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            owner_q          <= OWN_NONE;
            starve_cnt_q     <= '0;
            burst_cnt_q      <= '0;
            instr_addr_out_q <= '0;
        end else begin
            owner_q          <= owner_d;
            starve_cnt_q     <= starve_cnt_d;
            burst_cnt_q      <= burst_cnt_d;
            instr_addr_out_q <= instr_addr_out_d;
        end
    end

    // Memory read data is shared; the owner tag decides who sees a valid.
    assign instr_valid    = RSTb && (owner_q == OWN_INSTR);
    assign data_rvalid    = RSTb && (owner_q == OWN_DATA);
    assign dma_rvalid     = RSTb && (owner_q == OWN_DMA);
    assign instr_data     = mem_rdata;
    assign data_rdata     = mem_rdata;
    assign dma_rdata      = mem_rdata;
    assign instr_addr_out = instr_addr_out_q;

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// Directed bench for slurm16_memory_arbiter with a byte-writable memory model.
module tb_slurm16_memory_arbiter;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        instr_req;
    logic [14:0] instr_addr;
    logic        instr_grant, instr_valid;
    logic [15:0] instr_data;
    logic [14:0] instr_addr_out;
    logic        data_req, data_wr;
    logic [14:0] data_addr;
    logic [15:0] data_wdata;
    logic [1:0]  data_mask;
    logic        data_success, data_rvalid;
    logic [15:0] data_rdata;
    logic        dma_req, dma_wr;
    logic [14:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_grant, dma_rvalid;
    logic [15:0] dma_rdata;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic [1:0]  mem_wr_mask;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] mem [0:32767];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    slurm16_memory_arbiter #(.ADDR_BITS(15), .STARVE_LIMIT(4), .DMA_BURST_MAX(8)) dut (
        .CLK(CLK), .RSTb(RSTb),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_grant(instr_grant),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr_out(instr_addr_out),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_mask(data_mask), .data_success(data_success),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_grant(dma_grant), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr_mask(mem_wr_mask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory, one cycle read latency.
    always @(posedge CLK) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr_mask[0]) mem[mem_addr][7:0]  <= mem_wdata[7:0];
        if (mem_wr_mask[1]) mem[mem_addr][15:8] <= mem_wdata[15:8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_reqs();
        instr_req = 1'b0; instr_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_mask = 2'b00;
        dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic prev_dma;
        logic exp_f;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem_rdata = '0;
        idle_reqs();
        RSTb = 1'b0;
        tick();

        // Requests during reset are ignored.
        instr_req = 1'b1; dma_req = 1'b1; dma_wr = 1'b1;
        @(negedge CLK);
        check("rst_instr_grant", 32'(instr_grant), 0);
        check("rst_dma_grant",   32'(dma_grant), 0);
        check("rst_mem_rd",      32'(mem_rd), 0);
        check("rst_wr_mask",     32'(mem_wr_mask), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_addr_out",    32'(instr_addr_out), 0);
        tick();
        idle_reqs();
        RSTb = 1'b1;

        // Fetch stream 0,1,2.
        for (int n = 0; n < 4; n++) begin
            instr_req  = (n < 3);
            instr_addr = 15'(n);
            @(negedge CLK);
            check("fetch_grant", 32'(instr_grant), (n < 3) ? 1 : 0);
            if (n < 3) check("fetch_mem_addr", 32'(mem_addr), n);
            check("fetch_valid", 32'(instr_valid), (n > 0) ? 1 : 0);
            if (n > 0) begin
                check("fetch_data", 32'(instr_data), 32'h1000 + n - 1);
                check("fetch_addr_out", 32'(instr_addr_out), n - 1);
            end
            tick();
        end

        // Load beats fetch, fetch resumes next cycle.
        instr_req = 1'b1; instr_addr = 15'd5;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 15'h40;
        @(negedge CLK);
        check("ld_success", 32'(data_success), 1);
        check("ld_instr_grant", 32'(instr_grant), 0);
        check("ld_mem_addr", 32'(mem_addr), 32'h40);
        check("ld_mem_rd", 32'(mem_rd), 1);
        tick();
        data_req = 1'b0;
        @(negedge CLK);
        check("ld_rvalid", 32'(data_rvalid), 1);
        check("ld_rdata", 32'(data_rdata), 32'h1040);
        check("ld_fetch_resume", 32'(instr_grant), 1);
        check("ld_no_ivalid", 32'(instr_valid), 0);
        tick();
        instr_req = 1'b0;
        @(negedge CLK);
        check("ld_ivalid", 32'(instr_valid), 1);
        check("ld_idata", 32'(instr_data), 32'h1005);
        check("ld_no_rvalid", 32'(data_rvalid), 0);
        tick();

        // Starvation: fetch forced on the fifth contested cycle.
        for (int c = 0; c < 6; c++) begin
            instr_req = 1'b1; instr_addr = 15'd7;
            data_req = 1'b1; data_wr = 1'b0; data_addr = 15'h20;
            @(negedge CLK);
            check("starve_data", 32'(data_success), (c != 4) ? 1 : 0);
            check("starve_fetch", 32'(instr_grant), (c == 4) ? 1 : 0);
            tick();
        end
        idle_reqs();
        tick();

        // DMA reads with fetch pending from cycle 3: starvation forces fetch at 7.
        prev_dma = 1'b0;
        for (int c = 0; c < 12; c++) begin
            dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 15'(48 + c);
            instr_req = (c >= 3); instr_addr = 15'd9;
            exp_f = (c == 7);
            @(negedge CLK);
            check("burst_dma_grant", 32'(dma_grant), 32'(!exp_f));
            check("burst_fetch_grant", 32'(instr_grant), 32'(exp_f));
            if (c > 0) check("burst_dma_rvalid", 32'(dma_rvalid), 32'(prev_dma));
            if (c > 0 && prev_dma) check("burst_dma_rdata", 32'(dma_rdata), 32'h1000 + 48 + c - 1);
            prev_dma = !exp_f;
            tick();
        end
        idle_reqs();
        tick();

        // DMA burst limit: fetch from cycle 5 wins at 8 through the yield.
        for (int c = 0; c < 10; c++) begin
            dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 15'd60;
            instr_req = (c >= 5); instr_addr = 15'd11;
            @(negedge CLK);
            check("yield_dma_grant", 32'(dma_grant), (c != 8) ? 1 : 0);
            check("yield_fetch_grant", 32'(instr_grant), (c == 8) ? 1 : 0);
            tick();
        end
        idle_reqs();
        tick();

        // Low-byte store then load back.
        data_req = 1'b1; data_wr = 1'b1; data_mask = 2'b01; data_wdata = 16'hABCD; data_addr = 15'h10;
        @(negedge CLK);
        check("st_success", 32'(data_success), 1);
        check("st_wr_mask", 32'(mem_wr_mask), 32'h1);
        check("st_mem_rd", 32'(mem_rd), 0);
        check("st_wdata", 32'(mem_wdata), 32'hABCD);
        tick();
        data_wr = 1'b0; data_mask = 2'b00;
        @(negedge CLK);
        check("st_no_rvalid", 32'(data_rvalid), 0);
        check("st_ld_mem_rd", 32'(mem_rd), 1);
        tick();
        idle_reqs();
        @(negedge CLK);
        check("st_ld_rvalid", 32'(data_rvalid), 1);
        check("st_ld_rdata", 32'(data_rdata), 32'h10CD);
        tick();

        // Store with empty mask is still a granted cycle.
        data_req = 1'b1; data_wr = 1'b1; data_mask = 2'b00; data_addr = 15'h11;
        @(negedge CLK);
        check("st0_success", 32'(data_success), 1);
        check("st0_wr_mask", 32'(mem_wr_mask), 0);
        check("st0_mem_rd", 32'(mem_rd), 0);
        tick();
        idle_reqs();

        // DMA write waits behind a data load to the same word.
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 15'h50; dma_wdata = 16'h5555;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 15'h50;
        @(negedge CLK);
        check("dw_data_wins", 32'(data_success), 1);
        check("dw_dma_wait", 32'(dma_grant), 0);
        check("dw_wr_mask0", 32'(mem_wr_mask), 0);
        tick();
        data_req = 1'b0;
        @(negedge CLK);
        check("dw_dma_grant", 32'(dma_grant), 1);
        check("dw_wr_mask", 32'(mem_wr_mask), 32'h3);
        check("dw_old_rdata", 32'(data_rdata), 32'h1050);
        check("dw_rvalid", 32'(data_rvalid), 1);
        tick();
        idle_reqs();
        data_req = 1'b1; data_addr = 15'h50;
        @(negedge CLK);
        check("dw_no_dma_rvalid", 32'(dma_rvalid), 0);
        tick();
        idle_reqs();
        @(negedge CLK);
        check("dw_new_rdata", 32'(data_rdata), 32'h5555);
        tick();

        // Reset right after a fetch grant drops the pending valid.
        instr_req = 1'b1; instr_addr = 15'd3;
        @(negedge CLK);
        check("rr_grant", 32'(instr_grant), 1);
        RSTb = 1'b0;
        tick();
        @(negedge CLK);
        check("rr_ivalid", 32'(instr_valid), 0);
        check("rr_igrant", 32'(instr_grant), 0);
        check("rr_mem_rd", 32'(mem_rd), 0);
        tick();
        RSTb = 1'b1;
        idle_reqs();

        // Build up counters, then reset clears them.
        dma_req = 1'b1; dma_addr = 15'h31; instr_req = 1'b1; instr_addr = 15'd4;
        tick();
        tick();
        check("pre_starve", 32'(dut.starve_cnt_q), 2);
        check("pre_burst", 32'(dut.burst_cnt_q), 2);
        RSTb = 1'b0;
        tick();
        @(negedge CLK);
        check("rc_dma_rvalid", 32'(dma_rvalid), 0);
        check("rc_dma_grant", 32'(dma_grant), 0);
        check("rc_starve", 32'(dut.starve_cnt_q), 0);
        check("rc_burst", 32'(dut.burst_cnt_q), 0);
        tick();
        idle_reqs();
        RSTb = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
